collision_sequencer: RTL



---
 rtl/game_pkg.sv | 27 ++
 rtl/collision_sequencer_cmp.sv | 12 +
 rtl/collision_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared Floppy Bird geometry, coordinate type and collision-sequencer types.
package game_pkg;

  localparam int COORD_W  = 10;
  localparam int N_CHECKS = 5;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t BIRD_X  = 10'd100;
  localparam coord_t BIRD_W  = 10'd16;
  localparam coord_t BIRD_H  = 10'd16;
  localparam coord_t PIPE_W  = 10'd40;
  localparam coord_t FLOOR_Y = 10'd460;

  typedef enum logic {IDLE, CMP} state_t;

  typedef logic [2:0] cmp_idx_t;
  localparam cmp_idx_t LAST_IDX = 3'd4;

  // Add with one guard bit, clamping to the largest coordinate on overflow.
  function automatic coord_t sat_add(input coord_t a, input coord_t b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W] ? '1 : sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/collision_sequencer_cmp.sv
// Unsigned 10-bit greater-than comparator shared by all collision checks.
module collision_sequencer_cmp
  import game_pkg::*;
(
  input  coord_t A,
  input  coord_t B,
  output logic   true_false
);

  assign true_false = (A > B);

endmodule

// File: rtl/collision_sequencer.sv
// Per-frame collision checker: one comparator stepped through five checks,
// producing a registered hit / floor verdict with a one-cycle done pulse.
module collision_sequencer
  import game_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  coord_t              bird_y,
  input  coord_t              pipe_x,
  input  coord_t              gap_top,
  input  coord_t              gap_bottom,
  output logic                busy,
  output logic                done,
  output logic                hit,
  output logic                hit_floor,
  output logic [N_CHECKS-1:0] cmp_flags
);

  state_t                state, state_n;
  cmp_idx_t              idx, idx_n;
  logic [N_CHECKS-1:0]   flags, flags_n, cmp_flags_n;
  logic                  done_n, hit_n, hit_floor_n, load;
  coord_t                bird_y_q, pipe_x_q, gap_top_q, gap_bottom_q;
  coord_t                cmp_a, cmp_b, bird_bottom;
  logic                  cmp_gt;

  // NOTE: operand registers carry no reset; they are always loaded before use,
  // and keeping them out of the reset block avoids needless reset fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      bird_y_q     <= bird_y;
      pipe_x_q     <= pipe_x;
      gap_top_q    <= gap_top;
      gap_bottom_q <= gap_bottom;
    end
  end

  assign bird_bottom = sat_add(bird_y_q, BIRD_H);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    case (idx)
      3'd0: begin cmp_a = sat_add(pipe_x_q, PIPE_W); cmp_b = BIRD_X;       end
      3'd1: begin cmp_a = BIRD_X + BIRD_W;           cmp_b = pipe_x_q;     end
      3'd2: begin cmp_a = gap_top_q;                 cmp_b = bird_y_q;     end
      3'd3: begin cmp_a = bird_bottom;               cmp_b = gap_bottom_q; end
      3'd4: begin cmp_a = bird_bottom;               cmp_b = FLOOR_Y;      end
      default: ;
    endcase
  end

  collision_sequencer_cmp u_cmp (
    .A          (cmp_a),
    .B          (cmp_b),
    .true_false (cmp_gt)
  );

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    flags_n     = flags;
    done_n      = 1'b0;
    hit_n       = hit;
    hit_floor_n = hit_floor;
    cmp_flags_n = cmp_flags;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CMP;
          idx_n   = '0;
          flags_n = '0;
          load    = 1'b1;
        end
      end
      CMP: begin
        for (int i = 0; i < N_CHECKS; i++) begin
          if (idx == cmp_idx_t'(i)) flags_n[i] = cmp_gt;
        end
        if (idx == LAST_IDX) begin
          // Verdict uses flags_n so the final comparison lands in this same edge.
          state_n     = IDLE;
          idx_n       = '0;
          done_n      = 1'b1;
          cmp_flags_n = flags_n;
          hit_floor_n = flags_n[4];
          hit_n       = flags_n[4] | (flags_n[0] & flags_n[1] & (flags_n[2] | flags_n[3]));
        end else begin
          idx_n = idx + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      flags     <= '0;
      done      <= 1'b0;
      hit       <= 1'b0;
      hit_floor <= 1'b0;
      cmp_flags <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      flags     <= flags_n;
      done      <= done_n;
      hit       <= hit_n;
      hit_floor <= hit_floor_n;
      cmp_flags <= cmp_flags_n;
    end
  end

  assign busy = (state == CMP);

endmodule
